dbus_arbiter: RTL and testbench

- Arbitrates two bus masters onto the single shared data-bus slave port of the memsplit bus unit.
- Master 0 is udm and master 1 is the CPU data port.
- Replaces ad-hoc combinational muxing: fixed priority with a starvation guard, plus an in-order read-owner FIFO so several reads may be outstanding.
- Sits between udm_memsplit / cpu_wrapper data port and bus_unit_memsplit bus1.

---
 rtl/dbus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dbus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// dbus_arbiter
//   Puts two bus masters onto the one shared data-bus slave port:
//   master 0 = udm, master 1 = CPU data port.
//   - Master 0 has fixed priority. A starvation guard forces master 1 through
//     after STARVE_LIMIT consecutive master-0 transfers while master 1 waits.
//   - An in-order owner FIFO (RD_DEPTH entries) records who issued each
//     accepted read, so each slave response is routed back to its owner.
//   - orphan_o is sticky. It is set by a response that arrives while no read
//     is outstanding.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   m_req_i/m_we_i     per-master request / write enable (bit n = master n)
//   m_addr_bi/m_be_bi/m_wdata_bi   per-master request fields, packed by master
//   m_ack_o/m_resp_o/m_rdata_bo    per-master accept / read response / data
//   s_*                shared slave port
//   orphan_o           sticky unmatched-response flag
//   grant_cnt0_bo/grant_cnt1_bo    accepted-transfer counters
//
// Build option
//   DBUS_ARBITER_PERF_EN  when defined, the grant counters are implemented.
//                         When not defined, both counters are tied to 0.
module dbus_arbiter #(
  parameter int RD_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      m_req_i,
  input  logic [1:0]      m_we_i,
  input  logic [2*AW-1:0] m_addr_bi,
  input  logic [7:0]      m_be_bi,
  input  logic [63:0]     m_wdata_bi,
  output logic [1:0]      m_ack_o,
  output logic [1:0]      m_resp_o,
  output logic [63:0]     m_rdata_bo,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_bo,
  output logic [3:0]      s_be_bo,
  output logic [31:0]     s_wdata_bo,
  input  logic            s_ack_i,
  input  logic            s_resp_i,
  input  logic [31:0]     s_rdata_bi,
  output logic            orphan_o,
  output logic [31:0]     grant_cnt0_bo,
  output logic [31:0]     grant_cnt1_bo
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW:0]   DEPTH      = (PW+1)'(RD_DEPTH);

  logic [RD_DEPTH-1:0] owner_q;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         occ;
  logic [SW-1:0]       starve_cnt;
  logic                orphan_q;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic xfer;
  logic head_owner;
  logic win_vld;
  logic win_id;
  logic gnt_vld;
  logic gnt_id;

  assign fifo_empty = (occ == '0);
  assign head_owner = owner_q[rd_ptr];
  assign pop        = s_resp_i & ~fifo_empty;
  // A response popping in this cycle frees a slot for a read granted in the
  // same cycle. This allows push-with-pop at full occupancy.
  assign fifo_full  = (occ == DEPTH) & ~pop;

  // Priority winner. A read that cannot be accepted yields to a write from
  // the other master. If there is no such write, nothing is granted.
  always_comb begin
    win_vld = |m_req_i;
    win_id  = 1'b0;
    if (m_req_i == 2'b10)
      win_id = 1'b1;
    else if (m_req_i == 2'b11 && starve_cnt == STARVE_MAX)
      win_id = 1'b1;
    gnt_vld = win_vld;
    gnt_id  = win_id;
    if (win_vld && fifo_full && !m_we_i[win_id]) begin
      gnt_id  = ~win_id;
      gnt_vld = m_req_i[~win_id] & m_we_i[~win_id];
    end
  end

  always_comb begin
    s_req_o    = gnt_vld;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    m_ack_o    = '0;
    if (gnt_vld) begin
      s_we_o          = m_we_i[gnt_id];
      s_addr_bo       = gnt_id ? m_addr_bi[AW +: AW] : m_addr_bi[0 +: AW];
      s_be_bo         = gnt_id ? m_be_bi[4 +: 4] : m_be_bi[0 +: 4];
      s_wdata_bo      = gnt_id ? m_wdata_bi[32 +: 32] : m_wdata_bi[0 +: 32];
      m_ack_o[gnt_id] = s_ack_i;
    end
  end

  assign xfer = gnt_vld & s_ack_i;
  assign push = xfer & ~s_we_o;

  always_comb begin
    m_resp_o   = '0;
    m_rdata_bo = '0;
    if (pop) begin
      m_resp_o[head_owner] = 1'b1;
      if (head_owner)
        m_rdata_bo[63:32] = s_rdata_bi;
      else
        m_rdata_bo[31:0]  = s_rdata_bi;
    end
  end

  // Owner storage is not reset. Only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push)
      owner_q[wr_ptr] <= gnt_id;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      starve_cnt <= '0;
      orphan_q   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // An empty-FIFO response cannot match a read pushed in the same cycle.
      if (s_resp_i && fifo_empty)
        orphan_q <= 1'b1;
      if (!m_req_i[1] || (xfer && gnt_id))
        starve_cnt <= '0;
      else if (xfer && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign orphan_o = orphan_q;

`ifdef DBUS_ARBITER_PERF_EN
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (xfer) begin
      if (gnt_id)
        cnt1_q <= cnt1_q + 1'b1;
      else
        cnt0_q <= cnt0_q + 1'b1;
    end
  end

  assign grant_cnt0_bo = cnt0_q;
  assign grant_cnt1_bo = cnt1_q;
`else
  assign grant_cnt0_bo = '0;
  assign grant_cnt1_bo = '0;
`endif

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter
//   Directed bench for dbus_arbiter. Master and slave behaviour comes from
//   queues. A transaction-level reference model checks every cycle. Literal
//   expectations cover the grant pattern, response routing, orphan handling
//   and the grant counters.
module tb_dbus_arbiter;
  localparam int RD_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int AW           = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [1:0]      m_req_i;
  logic [1:0]      m_we_i;
  logic [2*AW-1:0] m_addr_bi;
  logic [7:0]      m_be_bi;
  logic [63:0]     m_wdata_bi;
  logic [1:0]      m_ack_o;
  logic [1:0]      m_resp_o;
  logic [63:0]     m_rdata_bo;
  logic            s_req_o;
  logic            s_we_o;
  logic [AW-1:0]   s_addr_bo;
  logic [3:0]      s_be_bo;
  logic [31:0]     s_wdata_bo;
  logic            s_ack_i;
  logic            s_resp_i;
  logic [31:0]     s_rdata_bi;
  logic            orphan_o;
  logic [31:0]     grant_cnt0_bo;
  logic [31:0]     grant_cnt1_bo;

  dbus_arbiter #(.RD_DEPTH(RD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_bi(m_addr_bi),
    .m_be_bi(m_be_bi), .m_wdata_bi(m_wdata_bi),
    .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_bo(m_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
    .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
    .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
    .orphan_o(orphan_o),
    .grant_cnt0_bo(grant_cnt0_bo), .grant_cnt1_bo(grant_cnt1_bo)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  txn_t        mq0[$];
  txn_t        mq1[$];
  rsp_t        rq[$];
  logic [1:0]  acked = '0;
  int          cyc = 0;
  int          rsp_delay = 5;
  bit          force_resp = 0;
  logic [31:0] force_data = '0;

  int          glog[$];
  logic [32:0] rlog[$];
  int          w1 = 0;
  int          w1_max = 0;
  bit          ack0_with_resp = 0;

  // master drivers: hold the head transaction until it is acked
  initial begin
    m_req_i = '0; m_we_i = '0; m_addr_bi = '0; m_be_bi = '0; m_wdata_bi = '0;
    forever begin
      @(posedge clk_i); #1;
      if (acked[0] && mq0.size() > 0) void'(mq0.pop_front());
      if (acked[1] && mq1.size() > 0) void'(mq1.pop_front());
      m_req_i = '0; m_we_i = '0; m_addr_bi = '0; m_be_bi = '0; m_wdata_bi = '0;
      if (mq0.size() > 0) begin
        m_req_i[0] = 1'b1; m_we_i[0] = mq0[0].we; m_addr_bi[0 +: AW] = mq0[0].addr;
        m_be_bi[0 +: 4] = mq0[0].be; m_wdata_bi[0 +: 32] = mq0[0].wdata;
      end
      if (mq1.size() > 0) begin
        m_req_i[1] = 1'b1; m_we_i[1] = mq1[0].we; m_addr_bi[AW +: AW] = mq1[0].addr;
        m_be_bi[4 +: 4] = mq1[0].be; m_wdata_bi[32 +: 32] = mq1[0].wdata;
      end
    end
  end

  // slave: returns addr ^ C0DE0000 rsp_delay cycles after each accepted read
  initial begin
    s_ack_i = 1'b1; s_resp_i = 1'b0; s_rdata_bi = '0;
    forever begin
      @(posedge clk_i); cyc++; #1;
      s_resp_i = 1'b0; s_rdata_bi = '0;
      if (force_resp) begin
        s_resp_i = 1'b1; s_rdata_bi = force_data; force_resp = 0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        s_resp_i = 1'b1; s_rdata_bi = rq[0].data; void'(rq.pop_front());
      end
    end
  end

  // observation: protocol handshakes and logs used by the literal checks
  initial forever begin
    @(negedge clk_i);
    acked = rst_i ? 2'b00 : m_ack_o;
    if (!rst_i) begin
      if (s_req_o && s_ack_i && !s_we_o)
        rq.push_back('{due: cyc + rsp_delay, data: s_addr_bo ^ 32'hC0DE_0000});
      if (m_ack_o[0]) glog.push_back(0);
      if (m_ack_o[1]) glog.push_back(1);
      if (m_resp_o[0]) rlog.push_back({1'b0, m_rdata_bo[31:0]});
      if (m_resp_o[1]) rlog.push_back({1'b1, m_rdata_bo[63:32]});
      if (m_ack_o[0] && m_resp_o[1]) ack0_with_resp = 1;
      if (m_req_i[1] && !m_ack_o[1]) begin
        w1++;
        if (w1 > w1_max) w1_max = w1;
      end else begin
        w1 = 0;
      end
    end
  end

  // reference model: owners as a queue of master ids, starvation as a plain count
  int          mo_q[$];
  int          m_starve = 0;
  bit          m_orphan = 0;
  logic [31:0] m_cnt0 = '0;
  logic [31:0] m_cnt1 = '0;

  initial forever begin
    int          win;
    bit          room;
    logic [69:0] e_s;
    logic [1:0]  e_ack;
    logic [1:0]  e_resp;
    logic [63:0] e_rdata;
    logic [63:0] e_perf;
    @(negedge clk_i);
    if (rst_i) begin
      mo_q.delete(); m_starve = 0; m_orphan = 0; m_cnt0 = '0; m_cnt1 = '0;
    end else begin
      room = (mo_q.size() < RD_DEPTH) || (s_resp_i && mo_q.size() > 0);
      win = -1;
      if (m_req_i[0] && !(m_req_i[1] && m_starve == STARVE_LIMIT)) win = 0;
      else if (m_req_i[1]) win = 1;
      if (win >= 0 && !m_we_i[win] && !room) begin
        if (m_req_i[1-win] && m_we_i[1-win]) win = 1 - win;
        else win = -1;
      end
      e_s = '0; e_ack = '0; e_resp = '0; e_rdata = '0;
      if (win >= 0) begin
        e_s = {1'b1, m_we_i[win], m_be_bi[win*4 +: 4], m_addr_bi[win*AW +: AW],
               m_wdata_bi[win*32 +: 32]};
        e_ack[win] = s_ack_i;
      end
      if (s_resp_i && mo_q.size() > 0) begin
        e_resp[mo_q[0]] = 1'b1;
        e_rdata[mo_q[0]*32 +: 32] = s_rdata_bi;
      end
`ifdef DBUS_ARBITER_PERF_EN
      e_perf = {m_cnt0, m_cnt1};
`else
      e_perf = '0;
`endif
      chk("slave_side", {s_req_o, s_we_o, s_be_bo, s_addr_bo, s_wdata_bo}, e_s);
      chk("master_side", {m_ack_o, m_resp_o, m_rdata_bo}, {e_ack, e_resp, e_rdata});
      chk("orphan", orphan_o, m_orphan);
      chk("grant_cnt", {grant_cnt0_bo, grant_cnt1_bo}, e_perf);
      if (s_resp_i) begin
        if (mo_q.size() > 0) void'(mo_q.pop_front());
        else m_orphan = 1;
      end
      if (win >= 0 && s_ack_i) begin
        if (!m_we_i[win]) mo_q.push_back(win);
        if (win == 0) m_cnt0 = m_cnt0 + 1; else m_cnt1 = m_cnt1 + 1;
      end
      if (!m_req_i[1]) m_starve = 0;
      else if (win == 1 && s_ack_i) m_starve = 0;
      else if (win == 0 && s_ack_i && m_starve < STARVE_LIMIT) m_starve++;
    end
  end

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic wait_masters_idle(input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget; i++) begin
      if (mq0.size() == 0 && mq1.size() == 0) begin idle = 1; break; end
      step();
    end
    chk("masters_idle_timeout", idle, 1'b1);
  endtask

  task automatic drain(input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget; i++) begin
      if (mq0.size() == 0 && mq1.size() == 0 && rq.size() == 0 && !force_resp) begin
        idle = 1; break;
      end
      step();
    end
    chk("drain_timeout", idle, 1'b1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
    return t;
  endfunction

  initial begin
    logic [26:0] pat27;
    logic [5:0]  pat6;
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_outputs", {orphan_o, m_resp_o, m_ack_o, s_req_o}, '0);
    step();

    // both masters stream writes: 8 x m0, 1 x m1, repeating
    glog.delete(); w1_max = 0;
    for (int i = 0; i < 24; i++) mq0.push_back(mk(1'b1, 32'h1000 + 4*i, 4'hF, i));
    for (int i = 0; i < 3; i++)  mq1.push_back(mk(1'b1, 32'h2000 + 4*i, 4'h3, 32'hA000 + i));
    drain(200);
    chk("starve_len", glog.size(), 27);
    pat27 = '0;
    foreach (glog[i]) if (i < 27 && glog[i] == 1) pat27[i] = 1'b1;
    chk("starve_pattern", pat27, 27'b100000000_100000000_100000000);
    chk("m1_max_wait", w1_max, 8);

    // m1 fills the owner FIFO, and the m0 read waits for the first response
    glog.delete(); rlog.delete(); rsp_delay = 5; ack0_with_resp = 0;
    for (int i = 0; i < 4; i++) mq1.push_back(mk(1'b0, 32'h100 + 4*i, 4'hF, 0));
    wait_masters_idle(50);
    mq0.push_back(mk(1'b0, 32'h200, 4'hF, 0));
    drain(100);
    chk("rd_resp_count", rlog.size(), 5);
    if (rlog.size() == 5) begin
      chk("rd_resp0", rlog[0], {1'b1, 32'hC0DE_0100});
      chk("rd_resp1", rlog[1], {1'b1, 32'hC0DE_0104});
      chk("rd_resp2", rlog[2], {1'b1, 32'hC0DE_0108});
      chk("rd_resp3", rlog[3], {1'b1, 32'hC0DE_010C});
      chk("rd_resp4", rlog[4], {1'b0, 32'hC0DE_0200});
    end
    chk("push_pop_at_full", ack0_with_resp, 1'b1);

    // FIFO full: the m0 read is blocked, so the m1 write goes first
    glog.delete(); rlog.delete(); rsp_delay = 8;
    for (int i = 0; i < 4; i++) mq0.push_back(mk(1'b0, 32'h300 + 4*i, 4'hF, 0));
    wait_masters_idle(50);
    mq0.push_back(mk(1'b0, 32'h310, 4'hF, 0));
    mq1.push_back(mk(1'b1, 32'h2100, 4'hC, 32'h5555_AAAA));
    drain(100);
    pat6 = '0;
    foreach (glog[i]) if (i < 6 && glog[i] == 1) pat6[i] = 1'b1;
    chk("blocked_read_order_len", glog.size(), 6);
    chk("blocked_read_order", pat6, 6'b010000);
    chk("blocked_read_resp_count", rlog.size(), 5);
    if (rlog.size() == 5) chk("blocked_read_last", rlog[4], {1'b0, 32'hC0DE_0310});

    // response with no outstanding read
    chk("orphan_before", orphan_o, 1'b0);
    force_data = 32'hDEAD_BEEF; force_resp = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("orphan_resp_dropped", {s_resp_i, m_resp_o, m_rdata_bo}, {1'b1, 2'b00, 64'd0});
    @(negedge clk_i);
    chk("orphan_set", orphan_o, 1'b1);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    chk("orphan_sticky", orphan_o, 1'b1);
    step();
    do_reset();
    @(negedge clk_i);
    chk("orphan_cleared_by_reset", orphan_o, 1'b0);
    step();

    // grant counters, then reset while a read is pending
    rsp_delay = 3;
    for (int i = 0; i < 3; i++) mq0.push_back(mk(1'b1, 32'h3000 + 4*i, 4'hF, 32'h77 + i));
    for (int i = 0; i < 2; i++) mq1.push_back(mk(1'b0, 32'h180 + 4*i, 4'hF, 0));
    drain(100);
`ifdef DBUS_ARBITER_PERF_EN
    chk("perf_counts", {grant_cnt0_bo, grant_cnt1_bo}, {32'd3, 32'd2});
`else
    chk("perf_counts", {grant_cnt0_bo, grant_cnt1_bo}, 64'd0);
`endif
    rsp_delay = 10;
    mq1.push_back(mk(1'b0, 32'h400, 4'hF, 0));
    wait_masters_idle(50);
    do_reset();
    @(negedge clk_i);
    chk("reset_mid_read", {orphan_o, grant_cnt0_bo, grant_cnt1_bo}, '0);
    drain(50);
    chk("late_resp_orphan", orphan_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
